// File: rtl/cond_branch_if.sv
// Branch-resolution bus between EX/ID and the conditional branch unit.
// The pipeline side uses the master modport; the unit uses the slave modport.
interface cond_branch_if #(
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
);
  logic              stall;
  logic              flush;
  logic              alu_negative;
  logic              alu_zero;
  logic              alu_overflow;
  logic              alu_carry_out;
  logic              set_flags;
  logic              br_valid;
  logic [1:0]        br_type;
  logic [3:0]        cond;
  logic [PC_W-1:0]   br_pc;
  logic [25:0]       br_imm;
  logic [63:0]       cb_val;
  logic              res_valid;
  logic              taken;
  logic [PC_W-1:0]   target;
  logic [3:0]        flags;
  logic [CNT_W-1:0]  cnt_resolved;
  logic [CNT_W-1:0]  cnt_taken;

  modport master (
    output stall, flush, alu_negative, alu_zero, alu_overflow, alu_carry_out,
           set_flags, br_valid, br_type, cond, br_pc, br_imm, cb_val,
    input  res_valid, taken, target, flags, cnt_resolved, cnt_taken
  );

  modport slave (
    input  stall, flush, alu_negative, alu_zero, alu_overflow, alu_carry_out,
           set_flags, br_valid, br_type, cond, br_pc, br_imm, cb_val,
    output res_valid, taken, target, flags, cnt_resolved, cnt_taken
  );
endinterface

// File: rtl/cond_branch_unit.sv
// LEGv8 branch resolver: NZVC flag register, B/B.cond/CBZ/CBNZ decision,
// target adder, one-cycle registered result and saturating branch counters.
module cond_branch_unit #(
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
) (
  input logic         clk,
  input logic         reset,
  cond_branch_if.slave bus
);
  localparam logic [1:0] BR_B    = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_CBZ  = 2'b10;
  localparam logic [1:0] BR_CBNZ = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       flags_q;
  logic             res_valid_q;
  logic             taken_q;
  logic [PC_W-1:0]  target_q;
  logic [CNT_W-1:0] cnt_res_q;
  logic [CNT_W-1:0] cnt_tak_q;

  logic [3:0]       live_flags;
  logic [3:0]       eff;
  logic             eff_n, eff_z, eff_v, eff_c;
  logic             cond_true;
  logic             decision;
  logic [25:0]      offset;
  logic [PC_W-1:0]  target_calc;
  logic             accept;

  // Handshake: br_valid is a one-cycle strobe with no ready; every unflushed,
  // unstalled strobe is resolved and shows as a res_valid pulse one cycle later.
  assign accept = bus.br_valid & ~bus.flush;

  // A flag-setting instruction in EX this cycle bypasses the flag register.
  assign live_flags = {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry_out};
  assign eff        = bus.set_flags ? live_flags : flags_q;
  assign eff_n      = eff[3];
  assign eff_z      = eff[2];
  assign eff_v      = eff[1];
  assign eff_c      = eff[0];

  always_comb begin
    cond_true = 1'b1;
    case (bus.cond)
      4'h0:    cond_true = eff_z;
      4'h1:    cond_true = ~eff_z;
      4'h2:    cond_true = eff_c;
      4'h3:    cond_true = ~eff_c;
      4'h4:    cond_true = eff_n;
      4'h5:    cond_true = ~eff_n;
      4'h6:    cond_true = eff_v;
      4'h7:    cond_true = ~eff_v;
      4'h8:    cond_true = eff_c & ~eff_z;
      4'h9:    cond_true = ~(eff_c & ~eff_z);
      4'hA:    cond_true = (eff_n == eff_v);
      4'hB:    cond_true = (eff_n != eff_v);
      4'hC:    cond_true = ~eff_z & (eff_n == eff_v);
      4'hD:    cond_true = ~(~eff_z & (eff_n == eff_v));
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    decision = 1'b1;
    case (bus.br_type)
      BR_B:    decision = 1'b1;
      BR_COND: decision = cond_true;
      BR_CBZ:  decision = (bus.cb_val == 64'd0);
      BR_CBNZ: decision = (bus.cb_val != 64'd0);
      default: decision = 1'b1;
    endcase
  end

  // B carries a 26-bit word offset; conditional forms carry 19 bits.
  always_comb begin
    if (bus.br_type == BR_B) offset = bus.br_imm;
    else                     offset = {{7{bus.br_imm[18]}}, bus.br_imm[18:0]};
  end

  assign target_calc = bus.br_pc + {{(PC_W-28){offset[25]}}, offset, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= 4'b0000;
      res_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      target_q    <= '0;
      cnt_res_q   <= '0;
      cnt_tak_q   <= '0;
    end else if (!bus.stall) begin
      if (bus.set_flags) flags_q <= live_flags;
      res_valid_q <= accept;
      taken_q     <= accept & decision;
      if (accept) begin
        target_q <= target_calc;
        if (cnt_res_q != '1) cnt_res_q <= cnt_res_q + CNT_ONE;
        if (decision && (cnt_tak_q != '1)) cnt_tak_q <= cnt_tak_q + CNT_ONE;
      end
    end
  end

  assign bus.res_valid    = res_valid_q;
  assign bus.taken        = taken_q;
  assign bus.target       = target_q;
  assign bus.flags        = flags_q;
  assign bus.cnt_resolved = cnt_res_q;
  assign bus.cnt_taken    = cnt_tak_q;
endmodule

// File: tb/tb_cond_branch_unit.sv
// Directed bench for cond_branch_unit; narrow counters so saturation is reachable.
module tb_cond_branch_unit;
  localparam int PC_W  = 64;
  localparam int CNT_W = 4;

  localparam logic [1:0] T_B = 2'b00, T_BC = 2'b01, T_CBZ = 2'b10, T_CBNZ = 2'b11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cond_branch_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  cond_branch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass   = 0;
  int n_checks = 0;

  logic [3:0]       e_flags;
  logic             e_rv;
  logic             e_tk;
  logic [63:0]      e_tgt;
  logic [CNT_W-1:0] e_res;
  logic [CNT_W-1:0] e_tak;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".flags"},     64'(bus.flags),        64'(e_flags));
    chk({tag, ".res_valid"}, 64'(bus.res_valid),    64'(e_rv));
    chk({tag, ".taken"},     64'(bus.taken),        64'(e_tk));
    chk({tag, ".target"},    bus.target,            e_tgt);
    chk({tag, ".cnt_res"},   64'(bus.cnt_resolved), 64'(e_res));
    chk({tag, ".cnt_tak"},   64'(bus.cnt_taken),    64'(e_tak));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input logic [3:0] c,
                       input logic [63:0] pc, input logic [25:0] imm, input logic [63:0] cbv);
    bus.br_valid = v;
    bus.br_type  = t;
    bus.cond     = c;
    bus.br_pc    = pc;
    bus.br_imm   = imm;
    bus.cb_val   = cbv;
  endtask

  task automatic set_alu(input logic sf, input logic [3:0] nzvc);
    bus.set_flags     = sf;
    bus.alu_negative  = nzvc[3];
    bus.alu_zero      = nzvc[2];
    bus.alu_overflow  = nzvc[1];
    bus.alu_carry_out = nzvc[0];
  endtask

  task automatic idle;
    drive(1'b0, T_B, 4'h0, 64'd0, 26'd0, 64'd0);
  endtask

  // Expected-result bookkeeping for one resolved branch, counters saturate.
  task automatic resolve(input logic tk, input logic [63:0] tgt);
    e_rv  = 1'b1;
    e_tk  = tk;
    e_tgt = tgt;
    if (e_res != {CNT_W{1'b1}}) e_res = e_res + 1'b1;
    if (tk && (e_tak != {CNT_W{1'b1}})) e_tak = e_tak + 1'b1;
  endtask

  task automatic no_res;
    e_rv = 1'b0;
    e_tk = 1'b0;
  endtask

  task automatic bcond(input logic [3:0] c, input logic exp_tk, input string tag);
    set_alu(1'b0, 4'b0000);
    drive(1'b1, T_BC, c, 64'h100, 26'd1, 64'd0);
    step;
    resolve(exp_tk, 64'h104);
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_alu(1'b0, 4'b0000);
    idle;
    step;
    reset = 1'b0;
    e_flags = 4'b0000; e_rv = 1'b0; e_tk = 1'b0; e_tgt = 64'd0; e_res = '0; e_tak = '0;
    check_all("reset");

    drive(1'b1, T_B, 4'h0, 64'h40, 26'd1, 64'd0);
    bus.flush = 1'b1;
    step;
    bus.flush = 1'b0;
    no_res;
    check_all("flush_cancel");

    idle;
    set_alu(1'b1, 4'b0101);
    step;
    e_flags = 4'b0101;
    check_all("flag_load");

    set_alu(1'b0, 4'b0000);
    drive(1'b1, T_BC, 4'h0, 64'h1000, 26'h007FFFF, 64'd0);
    step;
    resolve(1'b1, 64'hFFC);
    check_all("beq_neg_off");

    set_alu(1'b1, 4'b0000);
    drive(1'b1, T_BC, 4'h1, 64'h2000, 26'd4, 64'd0);
    step;
    e_flags = 4'b0000;
    resolve(1'b1, 64'h2010);
    check_all("bne_bypass");

    set_alu(1'b0, 4'b0101);
    drive(1'b1, T_BC, 4'h0, 64'h2000, 26'd0, 64'd0);
    step;
    resolve(1'b0, 64'h2000);
    check_all("beq_registered");

    idle;
    set_alu(1'b1, 4'b1000);
    step;
    e_flags = 4'b1000;
    no_res;
    check_all("set_n1v0");
    bcond(4'hA, 1'b0, "ge_n1v0");
    bcond(4'hB, 1'b1, "lt_n1v0");
    bcond(4'hC, 1'b0, "gt_n1v0");
    bcond(4'hD, 1'b1, "le_n1v0");

    idle;
    set_alu(1'b1, 4'b1010);
    step;
    e_flags = 4'b1010;
    no_res;
    check_all("set_n1v1");
    bcond(4'hC, 1'b1, "gt_n1v1");

    idle;
    set_alu(1'b1, 4'b0101);
    step;
    e_flags = 4'b0101;
    no_res;
    check_all("set_c1z1");
    bcond(4'h8, 1'b0, "hi_c1z1");
    bcond(4'h9, 1'b1, "ls_c1z1");

    drive(1'b1, T_CBZ, 4'h0, 64'h3000, 26'h007FFF8, 64'd0);
    step;
    resolve(1'b1, 64'h2FE0);
    check_all("cbz_zero");
    drive(1'b1, T_CBNZ, 4'h0, 64'h3000, 26'h007FFF8, 64'd0);
    step;
    resolve(1'b0, 64'h2FE0);
    check_all("cbnz_zero");
    drive(1'b1, T_CBZ, 4'h0, 64'h3000, 26'd2, 64'h8000000000000000);
    step;
    resolve(1'b0, 64'h3008);
    check_all("cbz_msb");
    drive(1'b1, T_CBNZ, 4'h0, 64'h3000, 26'd2, 64'h8000000000000000);
    step;
    resolve(1'b1, 64'h3008);
    check_all("cbnz_msb");

    drive(1'b1, T_B, 4'h0, 64'hFFFFFFFFFFFFFFFC, 26'd1, 64'd0);
    step;
    resolve(1'b1, 64'h0);
    check_all("b_wrap");
    drive(1'b1, T_B, 4'h0, 64'h0, 26'h0080000, 64'd0);
    step;
    resolve(1'b1, 64'h200000);
    check_all("b_imm26_pos");
    drive(1'b1, T_BC, 4'hE, 64'h500, 26'h2000001, 64'd0);
    step;
    resolve(1'b1, 64'h504);
    check_all("bal_imm19_field");
    drive(1'b1, T_B, 4'h0, 64'h100, 26'h3FFFFFF, 64'd0);
    step;
    resolve(1'b1, 64'hFC);
    check_all("b_imm26_neg");

    set_alu(1'b1, 4'b0010);
    drive(1'b1, T_B, 4'h0, 64'h700, 26'd1, 64'd0);
    bus.flush = 1'b1;
    step;
    bus.flush = 1'b0;
    e_flags = 4'b0010;
    no_res;
    check_all("flush_with_set_flags");

    set_alu(1'b0, 4'b0000);
    drive(1'b1, T_B, 4'h0, 64'h800, 26'd2, 64'd0);
    step;
    resolve(1'b1, 64'h808);
    check_all("pre_stall");

    bus.stall = 1'b1;
    set_alu(1'b1, 4'b1111);
    drive(1'b1, T_CBZ, 4'h0, 64'h9000, 26'd5, 64'd1);
    for (int i = 0; i < 3; i++) begin
      step;
      check_all($sformatf("stall_%0d", i));
    end
    bus.stall = 1'b0;
    set_alu(1'b0, 4'b0000);
    idle;
    step;
    no_res;
    check_all("post_stall");

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, T_B, 4'h0, 64'h1000, 26'd1, 64'd0);
      step;
      resolve(1'b1, 64'h1004);
      check_all($sformatf("sat_taken_%0d", i));
    end
    chk("cnt_res_saturated", 64'(bus.cnt_resolved), 64'hF);
    chk("cnt_tak_saturated", 64'(bus.cnt_taken), 64'hF);

    bus.stall = 1'b1;
    reset = 1'b1;
    set_alu(1'b1, 4'b1111);
    drive(1'b1, T_B, 4'h0, 64'h40, 26'd1, 64'd0);
    step;
    e_flags = 4'b0000; e_rv = 1'b0; e_tk = 1'b0; e_tgt = 64'd0; e_res = '0; e_tak = '0;
    check_all("reset_in_stall");
    reset = 1'b0;
    bus.stall = 1'b0;
    set_alu(1'b0, 4'b0000);
    idle;
    step;
    check_all("after_reset_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cond_branch_unit.md
Name: cond_branch_unit

Overview:
Consumer end of the ALU flag interface in the pipelined LEGv8 processor. Holds the architectural NZVC flag register and latches ALU negative/zero/overflow/carry_out when a flag-setting instruction (ADDS/SUBS/ANDS) completes EX. Resolves B, B.cond, CBZ and CBNZ against those flags or a register operand, computes the branch target, and registers the decision for the fetch/flush logic. Also keeps saturating resolved/taken branch counters for performance measurement.

Parameters:
PC_W, 64, PC and target width
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
stall  input  1  pipeline stall; freezes all state (flags, outputs, counters)
flush  input  1  squash; cancels a branch presented this cycle
alu_negative  input  1  ALU negative flag, current EX result
alu_zero  input  1  ALU zero flag
alu_overflow  input  1  ALU overflow flag
alu_carry_out  input  1  ALU carry_out flag
set_flags  input  1  EX instruction is flag-setting and valid
br_valid  input  1  branch instruction presented for resolution
br_type  input  2  00 B, 01 B.cond, 10 CBZ, 11 CBNZ
cond  input  4  B.cond condition code (LEGv8 encoding)
br_pc  input  PC_W  PC of the branch instruction
br_imm  input  26  word offset; B uses [25:0], others use [18:0]
cb_val  input  64  forwarded register operand for CBZ/CBNZ
res_valid  output  1  registered: a branch resolved last cycle
taken  output  1  registered: resolved branch is taken
target  output  PC_W  registered branch target
flags  output  4  architectural {N,Z,V,C}
cnt_resolved  output  CNT_W  count of resolved branches
cnt_taken  output  CNT_W  count of taken branches

Behaviour:
- Reset (sync, on clk edge with reset=1): flags=0000, res_valid=0, taken=0, target=0, counters=0. Reset overrides stall and flush.
- stall=1 (no reset): every register holds its value. res_valid also holds, so the consumer must qualify it with stall.
- Flag register: if set_flags=1 and stall=0, flags <= {alu_negative, alu_zero, alu_overflow, alu_carry_out} at the edge. Otherwise flags hold.
- Effective flags for evaluation (eff):
  - Same-cycle bypass: if set_flags=1, eff = live ALU flags.
  - Otherwise eff = registered flags.
- Condition codes, using eff N,Z,V,C:
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !(C&!Z)
  - A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE !GT
  - E, F always true
- Taken decision:
  - B: always taken.
  - B.cond: cond result.
  - CBZ: cb_val==0.
  - CBNZ: cb_val!=0.
  - CBZ/CBNZ ignore flags entirely.
- Target arithmetic:
  - target = br_pc + (sign_extend(offset) << 2), modulo 2^PC_W (wraps, no error).
  - offset is br_imm[25:0] for B and br_imm[18:0] otherwise.
  - Target is computed for taken and not-taken branches alike.
- Latency: one cycle. Inputs at edge k appear on res_valid/taken/target after edge k.
- Resolution, when stall=0:
  - res_valid <= br_valid & !flush.
  - taken <= br_valid & !flush & decision.
  - target <= computed value when br_valid & !flush; otherwise holds.
- flush with set_flags in the same cycle: the flag update still occurs. flush only cancels the branch.
- Counters (when stall=0 and res_valid is being set):
  - cnt_resolved increments on every resolution.
  - cnt_taken increments only on taken resolutions.
  - Both saturate at all-ones and never wrap.
- Back-to-back branches on consecutive cycles are each resolved independently. No internal state machine blocks acceptance.

Test Plan:
- Reset then idle: flags=0000, res_valid=0, counters=0. br_valid=1 with flush=1 leaves res_valid=0 and counters unchanged.
- Cycle 0: set_flags=1 with N=0,Z=1,V=0,C=1. Cycle 1: B.cond EQ, br_pc=0x1000, imm19=0x7FFFF (-1). Required next cycle: taken=1, target=0xFFC, flags=0101.
- Bypass: set_flags=1 with Z=0 (N=0,V=0,C=0) in the same cycle as B.cond NE, stored Z=1. Required: taken=1. Then B.cond EQ next cycle with no set_flags: taken=0.
- Signed conditions: flags N=1,V=0,Z=0. Required: GE 0, LT 1, GT 0, LE 1. Flags N=1,V=1,Z=0: GT 1. Flags C=1,Z=1: HI 0, LS 1.
- CBZ/CBNZ: cb_val=0 gives CBZ taken, CBNZ not taken. cb_val=64'h8000000000000000 gives the reverse. B with br_pc=0xFFFFFFFFFFFFFFFC, imm=1 gives target=0x0 (wrap).
- stall=1 for 3 cycles mid-stream: outputs and flags frozen despite set_flags/br_valid activity. Counters preset near all-ones (via long run or force) saturate rather than wrap. reset asserted during stall clears everything at the next edge.
